mem_stage: RTL
==============

# mem_stage

Memory stage of the 5-stage RISC-V pipeline, directly downstream of the execute stage. It holds the EX/MEM pipeline register and runs a load/store handshake with an external data-memory port. It formats load data and store data/byte-enables, and presents results to the write-back stage. It raises `StallM` to the hazard unit while a memory access is outstanding.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent in WAIT before the access is aborted.

Ports (`name direction width meaning`):
- `clk in 1` — rising-edge clock.
- `reset in 1` — asynchronous, active-high reset.
- `RegWriteE, MemWriteE in 1` — control signals from EX.
- `ResultSrcE in 2` — result select; `2'b01` marks a load.
- `funct3E in 3` — access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `rdE in 5` — destination register.
- `ALUResultE in 32` — effective address or ALU result.
- `WriteDataE in 32` — forwarded rs2 value (store data).
- `PCplus4E in 32` — link value.
- `RegWriteM out 1`, `ResultSrcM out 2`, `rdM out 5`, `ALUResultM out 32`, `PCplus4M out 32` — registered EX/MEM contents, passed to WB.
- `ReadDataM out 32` — registered, formatted load data.
- `StallM out 1` — freeze request for PC/IF/ID/EX.
- `dmem_req out 1`, `dmem_we out 1`, `dmem_addr out 32`, `dmem_wdata out 32`, `dmem_be out 4` — memory request.
- `dmem_ack in 1`, `dmem_rdata in 32` — memory response.
- `dmem_err out 1` — sticky timeout flag.

## Operation
- EX/MEM register:
  - Loads all E inputs on every edge where `StallM==0`; holds them otherwise.
  - A memop is pending when it is a load (`ResultSrcM==2'b01`) or `MemWriteM==1`.
- The FSM has three states: IDLE, WAIT, DONE.
  - IDLE, no memop: `dmem_req=0`, `StallM=0`.
  - IDLE, memop: `dmem_req=1`, `StallM=1`. On `dmem_ack` go to DONE, otherwise go to WAIT.
  - WAIT: `dmem_req=1`, `StallM=1`, wait counter increments. On `dmem_ack` go to DONE. When the counter reaches `TIMEOUT_CYCLES-1` without an ack, go to DONE, set `dmem_err`, and force `ReadDataM=0`.
  - DONE: `dmem_req=0`, `StallM=0`; the register advances. Always go to IDLE next.
- Request fields are valid whenever `dmem_req=1`:
  - `dmem_addr={ALUResultM[31:2],2'b00}`.
  - `dmem_we=MemWriteM`.
- On the ack edge of a load, `ReadDataM` captures the formatted `dmem_rdata`. `ReadDataM` holds until the next load completes.
- The request fields and the EX/MEM register are stable for the whole access. `dmem_ack` is ignored when `dmem_req=0`.
- `dmem_err` is cleared only by reset. The errored instruction still retires.
- Reset, including mid-access: all outputs go to 0, the state goes to IDLE, the counter clears, and the register holds a bubble. No request is re-issued.

## Timing
- A memop present in M in cycle t asserts `dmem_req` in cycle t.
- With an ack in cycle t+k, DONE is in cycle t+k+1 and the instruction leaves M at the end of t+k+1.
- Minimum cost is one stall cycle per memop (zero-wait memory). A non-memory instruction costs zero stall cycles.
- `StallM` is combinational from state and register contents. It has no combinational path from `dmem_ack`.

## Configuration
- `MEM_SUBWORD_EN` defined:
  - Byte enables:
    - Byte: `dmem_be = 4'b0001 << addr[1:0]`.
    - Halfword: `dmem_be = 4'b0011 << {addr[1],1'b0}`; `addr[0]` is ignored.
    - Word: `dmem_be = 4'b1111`.
  - Store data: replicated to the selected lanes.
  - Loads: the selected lane is extracted, then sign- or zero-extended per `funct3`.
- `MEM_SUBWORD_EN` undefined:
  - Every access is a word access: `dmem_be=4'b1111`, `dmem_wdata=WriteDataM`, `ReadDataM=dmem_rdata`.
  - `funct3E` is ignored.

## Test plan
- ADD (ResultSrc 00, MemWrite 0) → no `dmem_req`, `StallM` never high, M outputs equal E inputs one cycle later.
- LW at 0x100, ack in the same cycle, rdata 0xDEADBEEF:
  - `StallM` high for 1 cycle.
  - `ReadDataM=0xDEADBEEF` in DONE.
  - `dmem_addr=0x100`.
- SB of 0x000000A5 at 0x203, ack after 3 cycles (SUBWORD on):
  - `dmem_be=4'b1000`, `dmem_wdata[31:24]=0xA5`, `dmem_we=1`.
  - `StallM` high for 4 cycles.
- LB at 0x101, rdata 0x00008000 → `ReadDataM=0xFFFFFF80`. LBU at the same address → `ReadDataM=0x00000080`. With SUBWORD off → `ReadDataM=0x00008000`.
- Load with no ack and `TIMEOUT_CYCLES=4`:
  - `StallM` released after the timeout, `dmem_err=1`, `ReadDataM=0`.
  - The next instruction flows normally.
- Reset asserted in WAIT → `dmem_req`, `StallM` and all M outputs are 0 immediately; after release, state is IDLE with no request.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and the
// data-memory port. The stage is the master; the memory is the slave.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage RISC-V pipeline.
// Holds the EX/MEM register, runs the load/store handshake with the data
// memory (IDLE -> WAIT -> DONE), formats load/store data and raises StallM
// while an access is outstanding. A stuck access is aborted after
// TIMEOUT_CYCLES cycles in WAIT and flagged on the sticky dmem_err.
// Optional feature: define MEM_SUBWORD_EN for byte/halfword accesses;
// without it every access is a full word and funct3E is ignored.
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWriteE,
   input  logic              MemWriteE,
   input  logic [1:0]        ResultSrcE,
   input  logic [2:0]        funct3E,
   input  logic [4:0]        rdE,
   input  logic [31:0]       ALUResultE,
   input  logic [31:0]       WriteDataE,
   input  logic [31:0]       PCplus4E,
   output logic              RegWriteM,
   output logic [1:0]        ResultSrcM,
   output logic [4:0]        rdM,
   output logic [31:0]       ALUResultM,
   output logic [31:0]       PCplus4M,
   output logic [31:0]       ReadDataM,
   output logic              StallM,
   output logic              dmem_err,
   mem_stage_if.master       dmem
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             regwrite_q;
   logic             memwrite_q;
   logic [1:0]       resultsrc_q;
   logic [4:0]       rd_q;
   logic [31:0]      alu_q;
   logic [31:0]      wdata_q;
   logic [31:0]      pc4_q;

   logic             is_load;
   logic             memop;
   logic             req;
   logic             stall;
   logic [3:0]       be;
   logic [31:0]      wdata_fmt;
   logic [31:0]      rdata_fmt;

`ifdef MEM_SUBWORD_EN
   logic [2:0]       funct3_q;

   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 4'b0001 << a;
         2'b01:   return 4'b0011 << {a[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_fmt(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{a, 3'b000} +: 8];
      h = a[1] ? rd[31:16] : rd[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return rd;
      endcase
   endfunction

   assign be        = byte_en(funct3_q, alu_q[1:0]);
   assign wdata_fmt = store_fmt(funct3_q, wdata_q);
   assign rdata_fmt = load_fmt(funct3_q, alu_q[1:0], dmem.dmem_rdata);
`else
   logic unused_funct3;

   assign unused_funct3 = ^funct3E;
   assign be            = 4'b1111;
   assign wdata_fmt     = wdata_q;
   assign rdata_fmt     = dmem.dmem_rdata;
`endif

   assign is_load = (resultsrc_q == 2'b01);
   assign memop   = is_load | memwrite_q;

   // EX/MEM register: advances whenever the stage is not stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regwrite_q  <= 1'b0;
         memwrite_q  <= 1'b0;
         resultsrc_q <= 2'b00;
         rd_q        <= 5'd0;
         alu_q       <= 32'h0;
         wdata_q     <= 32'h0;
         pc4_q       <= 32'h0;
`ifdef MEM_SUBWORD_EN
         funct3_q    <= 3'b000;
`endif
      end else if (!stall) begin
         regwrite_q  <= RegWriteE;
         memwrite_q  <= MemWriteE;
         resultsrc_q <= ResultSrcE;
         rd_q        <= rdE;
         alu_q       <= ALUResultE;
         wdata_q     <= WriteDataE;
         pc4_q       <= PCplus4E;
`ifdef MEM_SUBWORD_EN
         funct3_q    <= funct3E;
`endif
      end
   end

   // Handshake FSM state, wait counter, load data and sticky error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state and handshake outputs; stall depends only on state and the
   // registered instruction so there is no path from dmem_ack to StallM
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      rdata_d = rdata_q;
      err_d   = err_q;
      req     = 1'b0;
      stall   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (memop) begin
               req   = 1'b1;
               stall = 1'b1;
               if (dmem.dmem_ack) begin
                  state_d = S_DONE;
                  if (is_load) rdata_d = rdata_fmt;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            req   = 1'b1;
            stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (dmem.dmem_ack) begin
               state_d = S_DONE;
               if (is_load) rdata_d = rdata_fmt;
            end else if (cnt_q == CNT_LAST) begin
               // Abort: the instruction retires with zeroed load data
               state_d = S_DONE;
               rdata_d = 32'h0;
               err_d   = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request fields are driven only while a request is active
   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = req & memwrite_q;
   assign dmem.dmem_addr  = req ? {alu_q[31:2], 2'b00} : 32'h0;
   assign dmem.dmem_wdata = req ? wdata_fmt : 32'h0;
   assign dmem.dmem_be    = req ? be : 4'b0000;

   assign StallM     = stall;
   assign RegWriteM  = regwrite_q;
   assign ResultSrcM = resultsrc_q;
   assign rdM        = rd_q;
   assign ALUResultM = alu_q;
   assign PCplus4M   = pc4_q;
   assign ReadDataM  = rdata_q;
   assign dmem_err   = err_q;

endmodule
